startshow_sequencer: RTL and testbench
======================================

// Module: startshow_sequencer
// PURPOSE
//  Sequences the title-screen attract show shown while mode==0: scrolls the big-tank banner,
//  then runs a timed duel between the two demo tanks, arbitrating their auto-shoot requests,
//  then holds. Drives the show enable, the per-tank auto-shoot levels and the banner x-offset
//  consumed by the start-show renderer; replaces its free-running clk_4Hz counters.
// PARAMETERS
//  STEP        5    banner x-offset increment per tick (pixels)
//  X_END       460  final banner x-offset; must be <= 511 (9-bit offset)
//  DUEL_TICKS  60   duration of the duel phase in ticks
//  SHOT_GAP    4    minimum ticks between a shot launch and the next grant
//  HOLD_TICKS  8    duration of the hold phase in ticks
// PORTS
//  clk            in   1  system/pixel clock; all logic on posedge clk
//  rst            in   1  asynchronous, active-high reset
//  tick_4hz       in   1  one-clk-wide 4 Hz strobe, synchronous to clk
//  mode           in   3  game mode; show runs only while mode==0
//  shell1_fb      in   1  demo tank 1 shell in flight (1 = busy)
//  shell2_fb      in   1  demo tank 2 shell in flight
//  show_en        out  1  enable for demo tank control/shell/display instances
//  sht1_auto      out  1  shoot request, tank 1 (level)
//  sht2_auto      out  1  shoot request, tank 2 (level)
//  bigtank_x_off  out  9  banner x-offset in pixels
//  phase          out  2  0 IDLE, 1 INTRO, 2 DUEL, 3 HOLD/DONE
//  show_done      out  1  one-clk pulse on entry to DONE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; tick/gap counters 0; turn token = tank 1.
//  - All outputs registered; state change is visible on outputs the next clk.
//  - mode!=0 in any state: next clk IDLE, all outputs 0, counters cleared, no done pulse.
//    Takes priority over a coincident tick. Mid-operation rst: async clear as above.
//  - IDLE: mode==0 -> INTRO; show_en=1, bigtank_x_off=0.
//  - INTRO (phase 1): per tick, sum = x_off + STEP evaluated at 10 bits (no wrap);
//    if sum >= X_END: x_off=X_END, go DUEL, gap counter := SHOT_GAP (first grant immediate).
//    Otherwise x_off=sum. Offset never exceeds X_END; it is held in DUEL/HOLD/DONE.
//  - DUEL (phase 2): duel counter +1 per tick; on the tick it reaches DUEL_TICKS -> HOLD,
//    both sht*_auto dropped on the same clk.
//    Grant (at most one sht*_auto high at a time): when no grant is outstanding,
//    gap>=SHOT_GAP and a tick occurs, grant token owner if its fb==0, else the other tank
//    if its fb==0, else none (retry next tick).
//    Granted sht*_auto stays high until that tank's fb rises (launch ack); on ack:
//    drop the request, token := other tank, gap := 0. Gap counter increments per tick
//    and saturates at SHOT_GAP.
//    A tank whose fb is already high is never granted.
//  - HOLD (phase 3): counts HOLD_TICKS ticks, then exits per CONFIGURATION.
//  - DONE (phase 3): show_en stays 1, sht*_auto 0, x_off=X_END; show_done pulses one clk on
//    entry; stays until mode!=0.
// CONFIGURATION
//  STARTSHOW_LOOP_EN defined: HOLD exit -> INTRO with x_off=0, token reset to tank 1,
//    duel counter 0; DONE unreachable, show_done never asserts.
//  Undefined: HOLD exit -> DONE.
// STRUCTURE
//  startshow_pkg: state encoding (IDLE/INTRO/DUEL/HOLD/DONE), phase codes, shared
//    timing defaults.
//  Sub-module startshow_shot_arb: token, gap counter and grant/ack logic for the two shooters.
//    Inputs: enable, tick, fb[1:0]. Outputs: sht[1:0].
// TESTING
//  1. rst high mid-DUEL with sht1_auto=1 -> all outputs 0 immediately, phase 0.
//  2. mode=0, default params -> x_off 0,5,..,455 on successive ticks, then 460 and phase 2
//     on tick 92; never 461+.
//  3. DUEL, both fb=0 -> sht1_auto first. fb1 rises -> sht1_auto drops, next clk.
//     sht2_auto is granted on the 4th tick after the launch.
//  4. Token owner busy (fb2=1, token=2), fb1=0 -> tank 1 granted; token stays fair afterwards.
//     Both busy -> no grant until one fb falls.
//  5. Tick and mode=3 on the same clk during INTRO -> IDLE, x_off=0, no offset step.
//  6. Without STARTSHOW_LOOP_EN, show_done pulses once 8 ticks after DUEL ends.
//     With it, x_off returns to 0 and phase 1, show_done stays 0.

Source files
------------

// File: rtl/startshow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : startshow_pkg                                                     |
// | Brief  : State encoding, phase codes and timing defaults for the title-    |
// |          screen attract-show sequencer.                                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package startshow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INTRO = 3'd1,
        ST_DUEL  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } show_state_t;

    // HOLD and DONE share the same externally visible phase code.
    localparam logic [1:0] c_PH_IDLE  = 2'd0;
    localparam logic [1:0] c_PH_INTRO = 2'd1;
    localparam logic [1:0] c_PH_DUEL  = 2'd2;
    localparam logic [1:0] c_PH_HOLD  = 2'd3;

    localparam int c_DEF_STEP       = 5;
    localparam int c_DEF_X_END      = 460;
    localparam int c_DEF_DUEL_TICKS = 60;
    localparam int c_DEF_SHOT_GAP   = 4;
    localparam int c_DEF_HOLD_TICKS = 8;

    // Counter width holding 0..max_val with one spare code, never below 1 bit.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/startshow_shot_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : startshow_shot_arb                                                |
// | Brief  : Turn token, shot-gap counter and grant/ack handshake for the two  |
// |          demo-tank shooters.                                               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module startshow_shot_arb
    import startshow_pkg::*;
#(
    parameter int SHOT_GAP = c_DEF_SHOT_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       arm,
    input  logic       tick,
    input  logic [1:0] fb,
    output logic [1:0] sht
);

    localparam int                 c_GAP_W   = cnt_width(SHOT_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(SHOT_GAP);

    logic [1:0]         r_sht;
    logic               r_token;      // 0: tank 1 owns the turn, 1: tank 2
    logic [c_GAP_W-1:0] r_gap;
    logic [c_GAP_W-1:0] w_gap_inc;
    logic [1:0]         w_pick;

    assign w_gap_inc = (r_gap == c_GAP_MAX) ? c_GAP_MAX : r_gap + 1'b1;

    // Token owner first, the other tank only if the owner's shell is still flying.
    always_comb begin
        w_pick = 2'b00;
        if (!fb[r_token]) begin
            w_pick[r_token] = 1'b1;
        end else if (!fb[!r_token]) begin
            w_pick[!r_token] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sht   <= 2'b00;
            r_token <= 1'b0;
            r_gap   <= '0;
        end else if (!enable) begin
            r_sht   <= 2'b00;
            r_token <= 1'b0;
            r_gap   <= arm ? c_GAP_MAX : '0;
        end else if (|(r_sht & fb)) begin
            // Launch ack: the turn passes to the tank that did not just fire.
            r_sht   <= 2'b00;
            r_token <= ~r_sht[1];
            r_gap   <= '0;
        end else if (tick) begin
            r_gap <= w_gap_inc;
            if ((r_sht == 2'b00) && (w_gap_inc == c_GAP_MAX)) begin
                r_sht <= w_pick;
            end
        end
    end

    assign sht = r_sht;

endmodule
`default_nettype wire

// File: rtl/startshow_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : startshow_sequencer                                               |
// | Brief  : Attract-show sequencer: banner scroll, timed demo-tank duel, hold.|
// |          Define STARTSHOW_LOOP_EN to loop the show instead of ending DONE. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module startshow_sequencer
    import startshow_pkg::*;
#(
    parameter int STEP       = c_DEF_STEP,
    parameter int X_END      = c_DEF_X_END,
    parameter int DUEL_TICKS = c_DEF_DUEL_TICKS,
    parameter int SHOT_GAP   = c_DEF_SHOT_GAP,
    parameter int HOLD_TICKS = c_DEF_HOLD_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_4hz,
    input  logic [2:0] mode,
    input  logic       shell1_fb,
    input  logic       shell2_fb,
    output logic       show_en,
    output logic       sht1_auto,
    output logic       sht2_auto,
    output logic [8:0] bigtank_x_off,
    output logic [1:0] phase,
    output logic       show_done
);

    localparam int                 c_CNT_W    = cnt_width((DUEL_TICKS > HOLD_TICKS) ? DUEL_TICKS : HOLD_TICKS);
    localparam logic [c_CNT_W-1:0] c_DUEL_END = c_CNT_W'(DUEL_TICKS);
    localparam logic [c_CNT_W-1:0] c_HOLD_END = c_CNT_W'(HOLD_TICKS);
    localparam logic [9:0]         c_STEP10   = 10'(STEP);
    localparam logic [9:0]         c_XEND10   = 10'(X_END);
    localparam logic [8:0]         c_XEND9    = 9'(X_END);

    show_state_t        r_state;
    logic               r_show_en;
    logic [8:0]         r_x_off;
    logic [1:0]         r_phase;
    logic               r_show_done;
    logic [c_CNT_W-1:0] r_tick_cnt;

    logic               w_run;
    logic [9:0]         w_sum;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_intro_done;
    logic               w_duel_end;
    logic               w_arb_en;
    logic [1:0]         w_sht;

    assign w_run        = (mode == 3'd0);
    // One spare bit so a step past X_END saturates instead of wrapping.
    assign w_sum        = {1'b0, r_x_off} + c_STEP10;
    assign w_cnt_inc    = r_tick_cnt + 1'b1;
    assign w_intro_done = w_run && (r_state == ST_INTRO) && tick_4hz && (w_sum >= c_XEND10);
    assign w_duel_end   = (r_state == ST_DUEL) && tick_4hz && (w_cnt_inc == c_DUEL_END);
    // Dropping enable on the closing tick clears both requests on the same clk as the phase change.
    assign w_arb_en     = w_run && (r_state == ST_DUEL) && !w_duel_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_show_en   <= 1'b0;
            r_x_off     <= '0;
            r_phase     <= c_PH_IDLE;
            r_show_done <= 1'b0;
            r_tick_cnt  <= '0;
        end else begin
            r_show_done <= 1'b0;
            if (!w_run) begin
                r_state    <= ST_IDLE;
                r_show_en  <= 1'b0;
                r_x_off    <= '0;
                r_phase    <= c_PH_IDLE;
                r_tick_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_INTRO;
                        r_show_en  <= 1'b1;
                        r_x_off    <= '0;
                        r_phase    <= c_PH_INTRO;
                        r_tick_cnt <= '0;
                    end
                    ST_INTRO: begin
                        if (tick_4hz) begin
                            if (w_sum >= c_XEND10) begin
                                r_x_off    <= c_XEND9;
                                r_state    <= ST_DUEL;
                                r_phase    <= c_PH_DUEL;
                                r_tick_cnt <= '0;
                            end else begin
                                r_x_off <= w_sum[8:0];
                            end
                        end
                    end
                    ST_DUEL: begin
                        if (tick_4hz) begin
                            if (w_duel_end) begin
                                r_state    <= ST_HOLD;
                                r_phase    <= c_PH_HOLD;
                                r_tick_cnt <= '0;
                            end else begin
                                r_tick_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (tick_4hz) begin
                            if (w_cnt_inc == c_HOLD_END) begin
                                r_tick_cnt <= '0;
`ifdef STARTSHOW_LOOP_EN
                                r_state    <= ST_INTRO;
                                r_phase    <= c_PH_INTRO;
                                r_x_off    <= '0;
`else
                                r_state     <= ST_DONE;
                                r_show_done <= 1'b1;
`endif
                            end else begin
                                r_tick_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_DONE;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_show_en  <= 1'b0;
                        r_x_off    <= '0;
                        r_phase    <= c_PH_IDLE;
                        r_tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    startshow_shot_arb #(
        .SHOT_GAP (SHOT_GAP)
    ) u_shot_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (w_arb_en),
        .arm    (w_intro_done),
        .tick   (tick_4hz),
        .fb     ({shell2_fb, shell1_fb}),
        .sht    (w_sht)
    );

    assign show_en       = r_show_en;
    assign sht1_auto     = w_sht[0];
    assign sht2_auto     = w_sht[1];
    assign bigtank_x_off = r_x_off;
    assign phase         = r_phase;
    assign show_done     = r_show_done;

endmodule
`default_nettype wire

// File: tb/tb_startshow_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_startshow_sequencer                                            |
// | Brief  : Randomized bench for startshow_sequencer against a tick-count     |
// |          reference model of the show timeline.                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_startshow_sequencer;

    localparam int c_STEP       = 5;
    localparam int c_X_END      = 460;
    localparam int c_DUEL_TICKS = 60;
    localparam int c_SHOT_GAP   = 4;
    localparam int c_HOLD_TICKS = 8;
    // The whole show is a timeline measured in ticks since INTRO began.
    localparam int c_INTRO_END  = (c_X_END + c_STEP - 1) / c_STEP;
    localparam int c_DUEL_END   = c_INTRO_END + c_DUEL_TICKS;
    localparam int c_SHOW_END   = c_DUEL_END + c_HOLD_TICKS;
`ifdef STARTSHOW_LOOP_EN
    localparam bit c_LOOP = 1'b1;
`else
    localparam bit c_LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_4hz = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       shell1_fb = 1'b0;
    logic       shell2_fb = 1'b0;
    logic       show_en;
    logic       sht1_auto;
    logic       sht2_auto;
    logic [8:0] bigtank_x_off;
    logic [1:0] phase;
    logic       show_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_active;
    int m_ticks;
    int m_grant;      // 0 none, 1 tank 1, 2 tank 2
    int m_token;      // 1 or 2
    int m_gap;
    bit m_pulse;

    bit disturb = 1'b0;
    int kill_cnt = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    startshow_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .tick_4hz      (tick_4hz),
        .mode          (mode),
        .shell1_fb     (shell1_fb),
        .shell2_fb     (shell2_fb),
        .show_en       (show_en),
        .sht1_auto     (sht1_auto),
        .sht2_auto     (sht2_auto),
        .bigtank_x_off (bigtank_x_off),
        .phase         (phase),
        .show_done     (show_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_ticks  = 0;
        m_grant  = 0;
        m_token  = 1;
        m_gap    = 0;
        m_pulse  = 1'b0;
    endfunction

    function automatic int model_phase();
        if (!m_active)                return 0;
        if (m_ticks < c_INTRO_END)    return 1;
        if (m_ticks < c_DUEL_END)     return 2;
        return 3;
    endfunction

    function automatic void model_step(input bit t, input logic [2:0] md, input bit f1, input bit f2);
        bit fbv[1:2];
        fbv[1] = f1;
        fbv[2] = f2;
        m_pulse = 1'b0;
        if (md != 3'd0) begin
            model_reset();
        end else if (!m_active) begin
            model_reset();
            m_active = 1'b1;
        end else begin
            if (model_phase() == 2) begin
                if (t && (m_ticks + 1 == c_DUEL_END)) begin
                    m_grant = 0;
                end else if ((m_grant != 0) && fbv[m_grant]) begin
                    m_token = 3 - m_grant;
                    m_grant = 0;
                    m_gap   = 0;
                end else if (t) begin
                    m_gap = (m_gap + 1 > c_SHOT_GAP) ? c_SHOT_GAP : m_gap + 1;
                    if ((m_grant == 0) && (m_gap == c_SHOT_GAP)) begin
                        if (!fbv[m_token])          m_grant = m_token;
                        else if (!fbv[3 - m_token]) m_grant = 3 - m_token;
                    end
                end
            end
            if (t && (m_ticks < c_SHOW_END)) begin
                if (m_ticks + 1 == c_INTRO_END) begin
                    m_gap   = c_SHOT_GAP;
                    m_token = 1;
                    m_grant = 0;
                end
                m_ticks++;
                if (m_ticks == c_SHOW_END) begin
                    if (c_LOOP) m_ticks = 0;
                    else        m_pulse = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        int ex;
        ex = m_ticks * c_STEP;
        if (ex > c_X_END) ex = c_X_END;
        if (!m_active)    ex = 0;
        check_eq("show_en",   show_en,       m_active);
        check_eq("phase",     phase,         model_phase());
        check_eq("x_off",     bigtank_x_off, ex);
        check_eq("sht1_auto", sht1_auto,     (m_grant == 1));
        check_eq("sht2_auto", sht2_auto,     (m_grant == 2));
        check_eq("show_done", show_done,     m_pulse);
    endtask

    // One clk: drive at negedge, advance the model at posedge, compare just after.
    task automatic drive_cycle(input bit f_tick, input bit f_kill, input bit hold_rst);
        @(negedge clk);
        rst = hold_rst;
        if (shell1_fb) begin
            if ($urandom % 6 == 0) shell1_fb = 1'b0;
        end else if ((sht1_auto && ($urandom % 3 == 0)) || ($urandom % 50 == 0)) begin
            shell1_fb = 1'b1;
        end
        if (shell2_fb) begin
            if ($urandom % 6 == 0) shell2_fb = 1'b0;
        end else if ((sht2_auto && ($urandom % 3 == 0)) || ($urandom % 50 == 0)) begin
            shell2_fb = 1'b1;
        end
        tick_4hz = f_tick ? 1'b1 : (!tick_4hz && ($urandom % 2 == 0));
        if (disturb && (kill_cnt == 0) && ($urandom % 400 == 0)) kill_cnt = $urandom_range(1, 3);
        if (f_kill) begin
            mode = 3'd3;
        end else if (kill_cnt > 0) begin
            mode = 3'($urandom_range(1, 7));
            kill_cnt--;
        end else begin
            mode = 3'd0;
        end
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(tick_4hz, mode, shell1_fb, shell2_fb);
        #1;
        check_outputs();
    endtask

    initial begin
        bit found;
        model_reset();

        repeat (2) drive_cycle(1'b0, 1'b0, 1'b1);

        // Run into the duel until tank 1 holds a grant, then hit the async reset.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            found = (model_phase() == 2) && (m_grant == 1);
        end
        check_eq("wait_duel_shot1", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_show_en", show_en,       0);
        check_eq("arst_sht1",    sht1_auto,     0);
        check_eq("arst_phase",   phase,         0);
        check_eq("arst_x_off",   bigtank_x_off, 0);
        model_reset();
        drive_cycle(1'b0, 1'b0, 1'b1);

        // Clean full show: either one DONE pulse or repeated loops.
        n_done = 0;
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            if (show_done) n_done++;
        end
        check_eq("done_pulses", n_done, c_LOOP ? 0 : 1);

        // Random mode interruptions across every phase.
        disturb = 1'b1;
        for (int i = 0; i < 2500; i++) drive_cycle(1'b0, 1'b0, 1'b0);
        disturb  = 1'b0;
        kill_cnt = 0;

        // Restart, then hit a tick and mode!=0 on the same clk mid-INTRO.
        drive_cycle(1'b0, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            found = (model_phase() == 1) && (m_ticks >= 2);
        end
        check_eq("wait_intro", found, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0);
        check_eq("kill_x_off", bigtank_x_off, 0);
        check_eq("kill_phase", phase, 0);
        for (int i = 0; i < 50; i++) drive_cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
